// File: rtl/fp_to_int_seq.sv
// Sequential fp32 -> signed int32 converter, truncating toward zero.
// Iterative STEP-bit shifter, saturating on overflow, with invalid/inexact flags.
module fp_to_int_seq #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        invalid,
    output logic        inexact
);

    localparam logic [4:0] STEP_N   = 5'(STEP);
    localparam logic [7:0] EXP_BIAS = 8'd127;
    localparam logic [7:0] EXP_M23  = 8'd150;
    localparam logic [7:0] EXP_SAT  = 8'd158;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIX   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_result;
    logic        r_invalid;
    logic        r_inexact;
    logic [31:0] r_acc;
    logic [4:0]  r_n;
    logic        r_left;
    logic        r_sign;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_frac_nz;
    logic [31:0] w_sat;
    logic [4:0]  w_n_in;
    logic [4:0]  w_k;
    logic [31:0] w_mask;
    logic        w_drop;

    assign w_sign    = a[31];
    assign w_exp     = a[30:23];
    assign w_frac    = a[22:0];
    assign w_frac_nz = |w_frac;
    assign w_sat     = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    // Only meaningful for exp in 127..157, where the distance to 150 fits in 5 bits.
    assign w_n_in    = (w_exp >= EXP_M23) ? 5'(w_exp - EXP_M23) : 5'(EXP_M23 - w_exp);

    // Per-cycle shift amount and the bits a right shift would discard.
    assign w_k    = (r_n < STEP_N) ? r_n : STEP_N;
    assign w_mask = (32'd1 << w_k) - 32'd1;
    assign w_drop = |(r_acc & w_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_invalid   <= 1'b0;
            r_inexact   <= 1'b0;
            r_acc       <= 32'd0;
            r_n         <= 5'd0;
            r_left      <= 1'b0;
            r_sign      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready  <= 1'b0;
                        r_sign      <= w_sign;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_invalid   <= 1'b0;
                        r_inexact   <= 1'b0;
                        if (w_exp == 8'hFF && w_frac_nz) begin
                            r_result  <= 32'h7FFF_FFFF;
                            r_invalid <= 1'b1;
                        end else if (w_exp == 8'hFF) begin
                            r_result  <= w_sat;
                            r_invalid <= 1'b1;
                        end else if (w_sign && w_exp == EXP_SAT && !w_frac_nz) begin
                            r_result <= 32'h8000_0000;
                        end else if (w_exp >= EXP_SAT) begin
                            r_result  <= w_sat;
                            r_invalid <= 1'b1;
                        end else if (w_exp == 8'd0) begin
                            r_result  <= 32'd0;
                            r_inexact <= w_frac_nz;
                        end else if (w_exp < EXP_BIAS) begin
                            r_result  <= 32'd0;
                            r_inexact <= 1'b1;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_acc       <= {8'h00, 1'b1, w_frac};
                            r_n         <= w_n_in;
                            r_left      <= (w_exp > EXP_M23);
                            r_state     <= (w_n_in == 5'd0) ? S_FIX : S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_left) begin
                        r_acc <= r_acc << w_k;
                    end else begin
                        r_acc <= r_acc >> w_k;
                        if (w_drop) r_inexact <= 1'b1;
                    end
                    r_n <= r_n - w_k;
                    if (r_n == w_k) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result    <= r_sign ? 32'(-r_acc) : r_acc;
                    r_invalid   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign invalid   = r_invalid;
    assign inexact   = r_inexact;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Bench for fp_to_int_seq: directed table on STEP=1, backpressure and reset
// sequences, and a random sweep of STEP=1,3,8 against a one-shot reference model.
module tb_fp_to_int_seq;

    localparam int NDUT = 3;
    localparam int NVEC = 11;
    localparam int NRND = 1000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic        in_ready_v [NDUT];
    logic        out_valid_v[NDUT];
    logic [31:0] res_v      [NDUT];
    logic        inv_v      [NDUT];
    logic        inx_v      [NDUT];

    int          steps[NDUT] = '{1, 3, 8};
    logic [31:0] got_res[NDUT];
    logic        got_inv[NDUT];
    logic        got_inx[NDUT];
    int          got_lat[NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_to_int_seq #(.STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]), .a(a),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .result(res_v[0]),
        .invalid(inv_v[0]), .inexact(inx_v[0])
    );
    fp_to_int_seq #(.STEP(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]), .a(a),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .result(res_v[1]),
        .invalid(inv_v[1]), .inexact(inx_v[1])
    );
    fp_to_int_seq #(.STEP(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]), .a(a),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .result(res_v[2]),
        .invalid(inv_v[2]), .inexact(inx_v[2])
    );

    task automatic chk(input string name, input int step, input logic [31:0] x,
                       input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s step=%0d a=%h got=%h expected=%h", name, step, x, got, expv);
        end
    endtask

    // One-shot reference: full-width shift of the significand, no iteration.
    task automatic ref_model(input logic [31:0] x, input int step, output logic [31:0] r,
                             output logic inv, output logic inx, output int lat);
        int          ex;
        int          e;
        int          n;
        logic [63:0] m;
        logic [63:0] mag;
        logic [63:0] lost;
        ex  = int'(x[30:23]);
        e   = ex - 127;
        inv = 1'b0;
        inx = 1'b0;
        lat = 1;
        r   = 32'd0;
        if (ex == 255 && x[22:0] != 23'd0) begin
            r = 32'h7FFF_FFFF; inv = 1'b1;
        end else if (ex == 255 || (e >= 31 && !(x[31] && e == 31 && x[22:0] == 23'd0))) begin
            r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; inv = 1'b1;
        end else if (e == 31) begin
            r = 32'h8000_0000;
        end else if (ex == 0) begin
            inx = (x[22:0] != 23'd0);
        end else if (e < 0) begin
            inx = 1'b1;
        end else begin
            m = {40'd0, 1'b1, x[22:0]};
            if (e >= 23) begin
                n   = e - 23;
                mag = m << n;
            end else begin
                n    = 23 - e;
                mag  = m >> n;
                lost = m & ((64'd1 << n) - 64'd1);
                inx  = (lost != 64'd0);
            end
            r   = x[31] ? (32'd0 - mag[31:0]) : mag[31:0];
            lat = 2 + (n + step - 1) / step;
        end
    endtask

    // Present x, then collect every DUT's output and its latency in cycles from accept.
    task automatic convert(input logic [31:0] x);
        logic got[NDUT];
        int   c;
        bit   all_done;
        for (int i = 0; i < NDUT; i++) got[i] = 1'b0;
        in_valid = 1'b1;
        a        = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        c        = 1;
        all_done = 1'b0;
        while (!all_done && c < 64) begin
            all_done = 1'b1;
            for (int i = 0; i < NDUT; i++) begin
                if (!got[i] && out_valid_v[i]) begin
                    got[i]     = 1'b1;
                    got_res[i] = res_v[i];
                    got_inv[i] = inv_v[i];
                    got_inx[i] = inx_v[i];
                    got_lat[i] = c;
                end
                if (!got[i]) all_done = 1'b0;
            end
            if (!all_done) begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            if (!got[i]) begin
                got_res[i] = 32'hDEAD_BEEF;
                got_inv[i] = 1'bx;
                got_inx[i] = 1'bx;
                got_lat[i] = -1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        tbl[NVEC];
        logic [31:0] w;
        logic [31:0] er;
        logic        ei;
        logic        ex;
        int          el;
        int          ov_seen;

        tbl[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25};
        tbl[1]  = '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 24};
        tbl[2]  = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2};
        tbl[3]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9};
        tbl[4]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        tbl[5]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1};
        tbl[6]  = '{32'h7F80_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1};
        tbl[7]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1};
        tbl[8]  = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1};
        tbl[9]  = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1};
        tbl[10] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("rst_in_ready", steps[i], 32'd0, 32'(in_ready_v[i]), 32'd1);
            chk("rst_out_valid", steps[i], 32'd0, 32'(out_valid_v[i]), 32'd0);
            chk("rst_result", steps[i], 32'd0, res_v[i], 32'd0);
            chk("rst_invalid", steps[i], 32'd0, 32'(inv_v[i]), 32'd0);
            chk("rst_inexact", steps[i], 32'd0, 32'(inx_v[i]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < NVEC; v++) begin
            convert(tbl[v].a);
            chk("vec_result", 1, tbl[v].a, got_res[0], tbl[v].res);
            chk("vec_invalid", 1, tbl[v].a, 32'(got_inv[0]), 32'(tbl[v].inv));
            chk("vec_inexact", 1, tbl[v].a, 32'(got_inx[0]), 32'(tbl[v].inx));
            chk("vec_latency", 1, tbl[v].a, 32'(got_lat[0]), 32'(tbl[v].lat));
        end

        // Backpressure: result must hold while out_ready stays low; a new request is ignored.
        in_valid = 1'b1;
        a        = 32'h3F80_0000;
        @(posedge clk);
        #1;
        a = 32'h4000_0000;
        for (int c = 0; c < 40 && !out_valid_v[0]; c++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_reached_done", 1, 32'h3F80_0000, 32'(out_valid_v[0]), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 1, 32'h3F80_0000, 32'(out_valid_v[0]), 32'd1);
            chk("bp_result", 1, 32'h3F80_0000, res_v[0], 32'h0000_0001);
            chk("bp_flags", 1, 32'h3F80_0000, {30'd0, inv_v[0], inx_v[0]}, 32'd0);
            chk("bp_in_ready", 1, 32'h3F80_0000, 32'(in_ready_v[0]), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 1, 32'h3F80_0000, 32'(out_valid_v[0]), 32'd0);
        chk("bp_release_ready", 1, 32'h3F80_0000, 32'(in_ready_v[0]), 32'd1);

        // Reset during the tenth SHIFT cycle of a 1.0 conversion aborts it.
        in_valid = 1'b1;
        a        = 32'h3F80_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_not_done", 1, 32'h3F80_0000, 32'(out_valid_v[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 1, 32'h3F80_0000, 32'(in_ready_v[0]), 32'd1);
        chk("mid_rst_out_valid", 1, 32'h3F80_0000, 32'(out_valid_v[0]), 32'd0);
        chk("mid_rst_result", 1, 32'h3F80_0000, res_v[0], 32'd0);
        chk("mid_rst_flags", 1, 32'h3F80_0000, {30'd0, inv_v[0], inx_v[0]}, 32'd0);
        ov_seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid_v[0]) ov_seen++;
        end
        chk("mid_rst_no_output", 1, 32'h3F80_0000, 32'(ov_seen), 32'd0);

        // Random sweep biased toward the normal range, including e==23.
        for (int r = 0; r < NRND; r++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[30:23] = 8'd150;
                1: w[30:23] = 8'($urandom_range(120, 160));
                2: w[30:23] = 8'($urandom_range(127, 157));
                default: ;
            endcase
            convert(w);
            for (int i = 0; i < NDUT; i++) begin
                ref_model(w, steps[i], er, ei, ex, el);
                chk("rnd_result", steps[i], w, got_res[i], er);
                chk("rnd_flags", steps[i], w, {30'd0, got_inv[i], got_inx[i]}, {30'd0, ei, ex});
                chk("rnd_latency", steps[i], w, 32'(got_lat[i]), 32'(el));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
